// File: rtl/vrf_wr_arbiter_pkg.sv
// Shared VRF writeback types, requester slot indices and lane geometry
// used by the per-lane write-port arbiter.
package vrf_wr_arbiter_pkg;

  localparam int unsigned NrLane = 2;
  localparam int unsigned DataW  = 32;
  localparam int unsigned AddrW  = 8;
  localparam int unsigned StrbW  = DataW / 8;
  localparam int unsigned IdW    = 4;

  typedef logic [DataW-1:0] vrf_data_t;
  typedef logic [AddrW-1:0] vrf_addr_t;
  typedef logic [StrbW-1:0] vrf_strb_t;
  typedef logic [IdW-1:0]   insn_id_t;

  typedef struct packed {
    vrf_data_t data;
    vrf_addr_t addr;
    vrf_strb_t strb;
    insn_id_t  id;
  } vrf_wr_req_t;

  localparam int unsigned WrReqVLU  = 0;
  localparam int unsigned WrReqVALU = 1;
  localparam int unsigned NumWrReq  = 2;

endpackage

// File: rtl/vrf_wr_arbiter_rr_burst_arb.sv
// Round-robin arbiter for one lane; the previous winner stays sticky until
// it has taken MaxBurst consecutive grants while others are waiting.
module rr_burst_arb #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned MaxBurst = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         valid_i,
  input  logic                      ready_i,
  output logic [NumReq-1:0]         gnt_c,
  output logic [$clog2(NumReq)-1:0] win_c
);

  localparam int unsigned IdxW   = $clog2(NumReq);
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);

  logic [IdxW-1:0]   last_q, last_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              found;
  logic              arb_en;
  int unsigned       cand;

  always_comb begin
    gnt_c   = '0;
    win_c   = last_q;
    found   = 1'b0;
    cand    = 0;
    last_d  = last_q;
    burst_d = burst_q;
    // Grants are suppressed while reset is asserted so nothing leaks through.
    arb_en  = ready_i & rst_ni;
    if (arb_en) begin
      if (valid_i[last_q] && (burst_q < BurstW'(MaxBurst))) begin
        found = 1'b1;
      end else begin
        // k == NumReq revisits last_q, so a lone exhausted requester still wins.
        for (int k = 1; k <= int'(NumReq); k++) begin
          cand = int'(unsigned'(last_q)) + k;
          if (cand >= NumReq) cand = cand - NumReq;
          if (!found && valid_i[IdxW'(cand)]) begin
            found = 1'b1;
            win_c = IdxW'(cand);
          end
        end
      end
      if (found) begin
        gnt_c[win_c] = 1'b1;
        if (win_c == last_q) begin
          burst_d = (burst_q == BurstW'(MaxBurst)) ? burst_q : burst_q + BurstW'(1);
        end else begin
          last_d  = win_c;
          burst_d = BurstW'(1);
        end
      end else begin
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q  <= IdxW'(NumReq - 1);
      burst_q <= '0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/vrf_wr_arbiter.sv
// Shares each lane's single VRF write port among the writeback requesters;
// grant is combinational, the bank write is registered one cycle later.
module vrf_wr_arbiter
  import vrf_wr_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = NumWrReq,
  parameter int unsigned MaxBurst = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic      [NumReq-1:0][NrLane-1:0]   req_valid_i,
  output logic      [NumReq-1:0][NrLane-1:0]   req_gnt_o,
  input  vrf_data_t [NumReq-1:0][NrLane-1:0]   req_data_i,
  input  vrf_addr_t [NumReq-1:0][NrLane-1:0]   req_addr_i,
  input  vrf_strb_t [NumReq-1:0][NrLane-1:0]   req_strb_i,
  input  insn_id_t  [NumReq-1:0][NrLane-1:0]   req_id_i,
  input  logic      [NrLane-1:0]               bank_ready_i,
  output logic      [NrLane-1:0]               vrf_wr_en_o,
  output vrf_addr_t [NrLane-1:0]               vrf_wr_addr_o,
  output vrf_data_t [NrLane-1:0]               vrf_wr_data_o,
  output vrf_strb_t [NrLane-1:0]               vrf_wr_strb_o,
  output insn_id_t  [NrLane-1:0]               vrf_wr_id_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic [NumReq-1:0] lane_valid [NrLane];
  logic [NumReq-1:0] lane_gnt   [NrLane];
  logic [IdxW-1:0]   lane_win   [NrLane];

  logic        [NrLane-1:0] wr_en_q, wr_en_d;
  vrf_wr_req_t [NrLane-1:0] wr_q, wr_d;

  for (genvar l = 0; l < int'(NrLane); l++) begin : g_lane
    rr_burst_arb #(
      .NumReq   (NumReq),
      .MaxBurst (MaxBurst)
    ) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (lane_valid[l]),
      .ready_i (bank_ready_i[l]),
      .gnt_c   (lane_gnt[l]),
      .win_c   (lane_win[l])
    );
  end

  // Transpose requester-major ports into per-lane vectors and mux the winner's payload.
  always_comb begin
    req_gnt_o = '0;
    wr_en_d   = '0;
    wr_d      = wr_q;
    for (int l = 0; l < int'(NrLane); l++) begin
      lane_valid[l] = '0;
      for (int r = 0; r < int'(NumReq); r++) begin
        lane_valid[l][r] = req_valid_i[r][l];
        req_gnt_o[r][l]  = lane_gnt[l][r];
      end
      wr_en_d[l] = |lane_gnt[l];
      if (wr_en_d[l]) begin
        wr_d[l].data = req_data_i[lane_win[l]][l];
        wr_d[l].addr = req_addr_i[lane_win[l]][l];
        wr_d[l].strb = req_strb_i[lane_win[l]][l];
        wr_d[l].id   = req_id_i[lane_win[l]][l];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_en_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
    end
  end

  // Payload registers carry no reset; they are only meaningful under wr_en.
  always_ff @(posedge clk_i) begin
    wr_q <= wr_d;
  end

  always_comb begin
    vrf_wr_en_o = wr_en_q;
    for (int l = 0; l < int'(NrLane); l++) begin
      vrf_wr_addr_o[l] = wr_q[l].addr;
      vrf_wr_data_o[l] = wr_q[l].data;
      vrf_wr_strb_o[l] = wr_q[l].strb;
      vrf_wr_id_o[l]   = wr_q[l].id;
    end
  end

endmodule

// File: tb/tb_vrf_wr_arbiter.sv
// Scoreboard bench for vrf_wr_arbiter: a rule-level model predicts grants and
// queues the expected bank write, which a monitor compares one cycle later.
module tb_vrf_wr_arbiter;
  import vrf_wr_arbiter_pkg::*;

  localparam int NUM = 3;
  localparam int MB  = 4;

  typedef struct packed {
    logic [NrLane-1:0]        en;
    vrf_wr_req_t [NrLane-1:0] p;
  } exp_t;

  logic                                 clk;
  logic                                 rst_ni;
  logic      [NUM-1:0][NrLane-1:0]      req_valid_i;
  logic      [NUM-1:0][NrLane-1:0]      req_gnt_o;
  vrf_data_t [NUM-1:0][NrLane-1:0]      req_data_i;
  vrf_addr_t [NUM-1:0][NrLane-1:0]      req_addr_i;
  vrf_strb_t [NUM-1:0][NrLane-1:0]      req_strb_i;
  insn_id_t  [NUM-1:0][NrLane-1:0]      req_id_i;
  logic      [NrLane-1:0]               bank_ready_i;
  logic      [NrLane-1:0]               vrf_wr_en_o;
  vrf_addr_t [NrLane-1:0]               vrf_wr_addr_o;
  vrf_data_t [NrLane-1:0]               vrf_wr_data_o;
  vrf_strb_t [NrLane-1:0]               vrf_wr_strb_o;
  insn_id_t  [NrLane-1:0]               vrf_wr_id_o;

  vrf_wr_arbiter #(.NumReq(NUM), .MaxBurst(MB)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_gnt_o     (req_gnt_o),
    .req_data_i    (req_data_i),
    .req_addr_i    (req_addr_i),
    .req_strb_i    (req_strb_i),
    .req_id_i      (req_id_i),
    .bank_ready_i  (bank_ready_i),
    .vrf_wr_en_o   (vrf_wr_en_o),
    .vrf_wr_addr_o (vrf_wr_addr_o),
    .vrf_wr_data_o (vrf_wr_data_o),
    .vrf_wr_strb_o (vrf_wr_strb_o),
    .vrf_wr_id_o   (vrf_wr_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb_q[$];
  logic [NUM-1:0][NrLane-1:0] clr;
  int   m_owner [NrLane];
  int   m_run   [NrLane];

  // Rule-level winner choice: the current owner keeps the port while its run
  // is short; otherwise the next waiting requester in rotation order wins.
  function automatic int pick(input int l);
    int c;
    if (!bank_ready_i[l]) return -1;
    if (req_valid_i[m_owner[l]][l] && m_run[l] < MB) return m_owner[l];
    for (int k = 1; k <= NUM; k++) begin
      c = (m_owner[l] + k) % NUM;
      if (req_valid_i[c][l]) return c;
    end
    return -1;
  endfunction

  task automatic new_payload(input int r, input int l);
    req_data_i[r][l] = $urandom;
    req_addr_i[r][l] = AddrW'($urandom);
    req_strb_i[r][l] = StrbW'($urandom);
    req_id_i[r][l]   = IdW'($urandom);
  endtask

  // Start a cycle: retire last cycle's granted requests.
  task automatic begin_cycle();
    @(negedge clk);
    cyc++;
    for (int r = 0; r < NUM; r++)
      for (int l = 0; l < int'(NrLane); l++)
        if (clr[r][l]) req_valid_i[r][l] = 1'b0;
    clr = '0;
  endtask

  task automatic refill(input int pct, input logic [NUM-1:0] mask);
    for (int r = 0; r < NUM; r++)
      for (int l = 0; l < int'(NrLane); l++)
        if (mask[r] && !req_valid_i[r][l] && $urandom_range(99) < pct) begin
          req_valid_i[r][l] = 1'b1;
          new_payload(r, l);
        end
  endtask

  // Predict and check this cycle's grants, queue the expected bank write.
  task automatic finish_cycle();
    exp_t e;
    logic [NUM-1:0] eg, ag;
    int w;
    #1;
    e = '0;
    for (int l = 0; l < int'(NrLane); l++) begin
      w  = rst_ni ? pick(l) : -1;
      eg = '0;
      ag = '0;
      if (w >= 0) eg[w] = 1'b1;
      for (int r = 0; r < NUM; r++) ag[r] = req_gnt_o[r][l];
      checks++;
      if (ag !== eg) begin
        errors++;
        $display("FAIL gnt lane%0d cyc%0d: got %b want %b", l, cyc, ag, eg);
      end
      if (!rst_ni) begin
        m_owner[l] = NUM - 1;
        m_run[l]   = 0;
      end else if (w >= 0) begin
        e.en[l]     = 1'b1;
        e.p[l].data = req_data_i[w][l];
        e.p[l].addr = req_addr_i[w][l];
        e.p[l].strb = req_strb_i[w][l];
        e.p[l].id   = req_id_i[w][l];
        clr[w][l]   = 1'b1;
        if (w == m_owner[l]) m_run[l] = (m_run[l] < MB) ? m_run[l] + 1 : MB;
        else begin
          m_owner[l] = w;
          m_run[l]   = 1;
        end
      end else if (bank_ready_i[l]) begin
        m_run[l] = 0;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic cycle(input int pct, input logic [NUM-1:0] mask, input int rdy_pct,
                       input logic rst_v);
    begin_cycle();
    rst_ni = rst_v;
    for (int l = 0; l < int'(NrLane); l++) bank_ready_i[l] = ($urandom_range(99) < rdy_pct);
    refill(pct, mask);
    finish_cycle();
  endtask

  // Monitor: each registered write is compared against the queued prediction.
  initial begin
    exp_t e;
    vrf_wr_req_t act;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int l = 0; l < int'(NrLane); l++) begin
          checks++;
          if (vrf_wr_en_o[l] !== e.en[l]) begin
            errors++;
            $display("FAIL wr_en lane%0d: got %b want %b", l, vrf_wr_en_o[l], e.en[l]);
          end
          if (e.en[l]) begin
            act = '{data: vrf_wr_data_o[l], addr: vrf_wr_addr_o[l],
                    strb: vrf_wr_strb_o[l], id: vrf_wr_id_o[l]};
            checks++;
            if (act !== e.p[l]) begin
              errors++;
              $display("FAIL wr_payload lane%0d: got %h want %h", l, act, e.p[l]);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = '0;
    req_data_i   = '0;
    req_addr_i   = '0;
    req_strb_i   = '0;
    req_id_i     = '0;
    bank_ready_i = '1;
    clr          = '0;
    for (int l = 0; l < int'(NrLane); l++) begin
      m_owner[l] = NUM - 1;
      m_run[l]   = 0;
    end

    repeat (2) cycle(0, '0, 100, 1'b0);

    // Requester 0 alone on lane 0 with addresses 5,6,7.
    for (int a = 5; a <= 7; a++) begin
      begin_cycle();
      rst_ni       = 1'b1;
      bank_ready_i = '1;
      req_valid_i  = '0;
      req_valid_i[WrReqVLU][0] = 1'b1;
      new_payload(WrReqVLU, 0);
      req_addr_i[WrReqVLU][0] = AddrW'(a);
      finish_cycle();
    end
    cycle(0, '0, 100, 1'b1);

    // Both units continuously valid: bursts of MaxBurst alternate.
    repeat (18) cycle(100, 3'b011, 100, 1'b1);

    // Two grants, one idle cycle, then both valid again.
    begin_cycle(); req_valid_i = '0; clr = '0; finish_cycle();
    repeat (2) cycle(100, 3'b001, 100, 1'b1);
    begin_cycle(); req_valid_i = '0; clr = '0; finish_cycle();
    repeat (10) cycle(100, 3'b011, 100, 1'b1);

    // Bank busy for two cycles mid-burst.
    begin_cycle(); req_valid_i = '0; clr = '0; finish_cycle();
    repeat (2) cycle(100, 3'b011, 100, 1'b1);
    repeat (2) cycle(100, 3'b011, 0, 1'b1);
    repeat (8) cycle(100, 3'b011, 100, 1'b1);

    // Lanes pick different requesters in the same cycle.
    begin_cycle();
    req_valid_i = '0;
    clr         = '0;
    req_valid_i[WrReqVALU][0] = 1'b1; new_payload(WrReqVALU, 0);
    req_valid_i[WrReqVLU][1]  = 1'b1; new_payload(WrReqVLU, 1);
    finish_cycle();

    // Reset while requester 1 is mid-burst, requester 0 then waiting.
    repeat (2) cycle(100, 3'b010, 100, 1'b1);
    cycle(100, 3'b011, 100, 1'b0);
    repeat (4) cycle(100, 3'b011, 100, 1'b1);

    // Random traffic with bank stalls and occasional resets.
    for (int i = 0; i < 400; i++)
      cycle(40, '1, 80, ($urandom_range(99) != 0));

    repeat (3) begin
      begin_cycle();
      req_valid_i = '0;
      clr         = '0;
      finish_cycle();
    end
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
